// File: rtl/sync_debounce_pkg.sv
// Shared types and helpers for the synchronise-and-debounce input bank.
package sync_debounce_pkg;

  // Debounce FSM: two settled levels, each with a pending-change state.
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } deb_state_t;

  // Bits needed to hold the values 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: synchroniser chain, tick-gated debounce FSM, registered edge pulses.
module debounce_channel
  import sync_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  input  logic tick_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned     CntW     = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax   = CntW'(DEBOUNCE_CYCLES - 1);
  localparam deb_state_t      RstState = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  deb_state_t             state_q, state_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  // Shift the raw input through the synchroniser; only the last stage is trusted.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_i};
    s      = sync_q[SYNC_STAGES-1];
  end

  // Debounce next state: a return to the old level cancels before any tick is considered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (tick_i) begin
          if (cnt_q == CntMax) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (tick_i) begin
          if (cnt_q == CntMax) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        state_d = RstState;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset drops any pending change without a pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q   <= '0;
      state_q <= RstState;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Stable level is high in the settled-high state and while a fall is still pending.
  always_comb begin
    out_o  = (state_q == STABLE_HI) || (state_q == WAIT_LO);
    rise_o = rise_q;
    fall_o = fall_q;
  end

endmodule

// File: rtl/sync_debounce_bank.sv
// Bank of independent synchronise-and-debounce channels with rise/fall event pulses.
module sync_debounce_bank
  import sync_debounce_pkg::*;
#(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned SYNC_STAGES     = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] sig_in,
  input  logic                tick,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_chan (
      .clk_i (clk),
      .rst_ni(rst),
      .sig_i (sig_in[i]),
      .tick_i(tick),
      .out_o (out[i]),
      .rise_o(rise[i]),
      .fall_o(fall[i])
    );
  end

endmodule

// File: tb/tb_sync_debounce_bank.sv
// Scoreboard bench for sync_debounce_bank: a level/run-length model predicts every cycle.
module tb_sync_debounce_bank;

  localparam int CH = 4;
  localparam int SS = 3;
  localparam int DC = 4;

  typedef struct packed {
    logic [CH-1:0] o;
    logic [CH-1:0] r;
    logic [CH-1:0] f;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] sig_in = '0;
  logic          tick = 1'b1;
  logic [CH-1:0] out, rise, fall;

  always #5 clk = ~clk;

  sync_debounce_bank #(
    .CHANNELS       (CH),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC),
    .RESET_LEVEL    (1'b0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sig_in(sig_in),
    .tick  (tick),
    .out   (out),
    .rise  (rise),
    .fall  (fall)
  );

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  // Model: delay line of raw samples, settled level, and count of ticks spent at a new level.
  bit m_pipe [CH][SS];
  bit m_lvl  [CH];
  bit m_wait [CH];
  int m_ticks[CH];

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < SS; k++) m_pipe[c][k] = 1'b0;
      m_lvl[c]   = 1'b0;
      m_wait[c]  = 1'b0;
      m_ticks[c] = 0;
    end
  endtask

  // Drive one cycle of inputs and push the prediction for the following rising edge.
  task automatic step(input logic [CH-1:0] s_in, input logic tk, input logic r);
    exp_t e;
    bit   s;
    @(negedge clk);
    sig_in = s_in;
    tick   = tk;
    rst    = r;
    e      = '0;
    if (!r) begin
      model_reset();
    end else begin
      for (int c = 0; c < CH; c++) begin
        s = m_pipe[c][SS-1];
        if (s != m_lvl[c]) begin
          // The edge that first sees the new level only arms the wait; later ticks count.
          if (!m_wait[c]) begin
            m_wait[c]  = 1'b1;
            m_ticks[c] = 0;
          end else if (tk) begin
            m_ticks[c]++;
            if (m_ticks[c] == DC) begin
              m_lvl[c]  = s;
              m_wait[c] = 1'b0;
              if (s) e.r[c] = 1'b1;
              else   e.f[c] = 1'b1;
            end
          end
        end else begin
          m_wait[c] = 1'b0;
        end
        for (int k = SS - 1; k > 0; k--) m_pipe[c][k] = m_pipe[c][k-1];
        m_pipe[c][0] = s_in[c];
      end
    end
    for (int c = 0; c < CH; c++) e.o[c] = m_lvl[c];
    sb_q.push_back(e);
  endtask

  // Monitor: compare each edge's outputs against the oldest prediction.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        checks++;
        if (out !== mon_e.o || rise !== mon_e.r || fall !== mon_e.f) begin
          failures++;
          $display("FAIL scoreboard t=%0t out=%h exp=%h rise=%h exp=%h fall=%h exp=%h",
                   $time, out, mon_e.o, rise, mon_e.r, fall, mon_e.f);
        end
      end
    end
  end

  logic [CH-1:0] cur;
  int            cyc;

  initial begin
    // Asynchronous reset takes effect before any clock edge.
    rst    = 1'b1;
    sig_in = 4'hF;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (out !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) begin
      failures++;
      $display("FAIL async_reset out=%h rise=%h fall=%h required 0/0/0", out, rise, fall);
    end
    model_reset();
    step(4'hF, 1'b1, 1'b0);
    step(4'hF, 1'b1, 1'b0);

    // Release with inputs high: out must rise on the 8th edge.
    for (int i = 0; i < 7; i++) step(4'hF, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    checks++;
    if (out !== 4'h0) begin
      failures++;
      $display("FAIL latency_edge7 out=%h required 0", out);
    end
    step(4'hF, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    checks++;
    if (out !== 4'hF || rise !== 4'hF) begin
      failures++;
      $display("FAIL latency_edge8 out=%h rise=%h required F/F", out, rise);
    end
    for (int i = 0; i < 4; i++) step(4'hF, 1'b1, 1'b1);

    // Back to all-low, then a clean step on ch0 up and down.
    cur = 4'h0;
    for (int i = 0; i < 12; i++) step(cur, 1'b1, 1'b1);
    cur[0] = 1'b1;
    for (int i = 0; i < 12; i++) step(cur, 1'b1, 1'b1);
    cur[0] = 1'b0;
    for (int i = 0; i < 12; i++) step(cur, 1'b1, 1'b1);

    // Bounce on ch1: 2 high, 1 low, 3 high, low; then a long hold high.
    cur[1] = 1'b1; repeat (2) step(cur, 1'b1, 1'b1);
    cur[1] = 1'b0; repeat (1) step(cur, 1'b1, 1'b1);
    cur[1] = 1'b1; repeat (3) step(cur, 1'b1, 1'b1);
    cur[1] = 1'b0; repeat (8) step(cur, 1'b1, 1'b1);
    cur[1] = 1'b1; repeat (12) step(cur, 1'b1, 1'b1);

    // Tick every 4th cycle with a step on ch2.
    cur[2] = 1'b1;
    for (int i = 0; i < 40; i++) step(cur, (i % 4) == 3, 1'b1);

    // ch3 stepped then reset three cycles later.
    cur[3] = 1'b1;
    repeat (3) step(cur, 1'b1, 1'b1);
    step(cur, 1'b1, 1'b0);
    cur = 4'h0;
    repeat (12) step(cur, 1'b1, 1'b1);

    // Simultaneous rise on ch0 and fall on ch1.
    cur = 4'b0010;
    repeat (12) step(cur, 1'b1, 1'b1);
    cur = 4'b0001;
    repeat (12) step(cur, 1'b1, 1'b1);

    // Randomised: slow level changes, short glitches, tick modes, rare resets.
    cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [CH-1:0] drv;
      logic          tk;
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 39) == 0) cur[c] = ~cur[c];
      end
      drv = cur;
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 14) == 0) drv[c] = ~drv[c];
      end
      case ((i / 250) % 3)
        0:       tk = 1'b1;
        1:       tk = (cyc % 4) == 0;
        default: tk = $urandom_range(0, 1) == 1;
      endcase
      cyc++;
      step(drv, tk, $urandom_range(0, 399) != 0);
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #4;
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_debounce_bank.md
Name: sync_debounce_bank

Overview:
- Multi-channel input conditioner for pushbuttons and switches feeding the CPU peripheral filter top.
- Each channel has a parametrised-depth synchroniser, a tick-gated debounce state machine, a registered stable level, and single-cycle rise/fall event pulses.
- Replaces the fixed 3-flop single-bit synchroniser stage and adds debounce and edge reporting.

Parameters:
- CHANNELS, 4: number of independent input channels (min 1).
- SYNC_STAGES, 3: flops in each synchroniser chain (min 2).
- DEBOUNCE_CYCLES, 16: ticks an input must hold a new level before acceptance (min 1).
- RESET_LEVEL, 1'b0: reset value of the sync chains and of out, for all channels.

Ports:
- clk  in  1  system clock; all flops are rising-edge.
- rst  in  1  asynchronous, active-low reset. Asserting (0) clears state immediately; deassertion is synchronous to clk upstream.
- sig_in  in  CHANNELS  raw asynchronous inputs.
- tick  in  1  debounce timebase strobe, one clk wide. Tie to 1 to count clk cycles.
- out  out  CHANNELS  debounced stable level per channel.
- rise  out  CHANNELS  1-cycle pulse when out[i] goes 0->1.
- fall  out  CHANNELS  1-cycle pulse when out[i] goes 1->0.

Behaviour:
- Reset (rst=0):
  - All sync flops and out = RESET_LEVEL.
  - rise = fall = 0.
  - Counters = 0.
  - FSM = STABLE_LO if RESET_LEVEL=0, else STABLE_HI.
  - Reset mid-debounce discards the pending change; no pulse is emitted.
- Synchroniser:
  - sync[0] <= sig_in[i]; sync[k] <= sync[k-1].
  - s = sync[SYNC_STAGES-1]. Only s is visible to the FSM.
- Per-channel FSM states:
  - STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
  - out = 1 in STABLE_HI and WAIT_LO; out = 0 otherwise.
- FSM transitions:
  - STABLE_LO with s=1 -> WAIT_HI, cnt<=0. STABLE_HI with s=0 -> WAIT_LO, cnt<=0.
  - WAIT_x with s back at the old level -> STABLE of the old level, cnt<=0, no pulse. Bounce check has priority over tick.
  - WAIT_x, s at the new level, tick=1, cnt==DEBOUNCE_CYCLES-1 -> STABLE of the new level. out toggles on that edge; rise or fall is 1 for exactly that cycle.
  - WAIT_x, s at the new level, tick=1, cnt<DEBOUNCE_CYCLES-1 -> cnt<=cnt+1.
  - WAIT_x with tick=0 -> cnt holds.
- Counter: width $clog2(DEBOUNCE_CYCLES+1). Never exceeds DEBOUNCE_CYCLES-1; no wrap.
- Latency with tick tied 1 and a clean step: out changes on edge SYNC_STAGES+DEBOUNCE_CYCLES+1, counted from the first edge that samples the new sig_in.
- Pulse exclusivity:
  - rise and fall are never both 1 on a channel.
  - Pulses are registered; there is no combinational path from sig_in.
- Channels are fully independent; simultaneous events on several channels each produce their own pulses in the same cycle.
- Glitches: any excursion of s shorter than DEBOUNCE_CYCLES ticks produces no out change.

Decomposition:
- Package sync_debounce_pkg:
  - Typedef enum logic [1:0] deb_state_t {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO}.
  - Function cnt_width(int) returning $clog2(n+1).
- Sub-module debounce_channel: one synchroniser chain, FSM and counter per channel, with the same parameters minus CHANNELS.
- sync_debounce_bank instantiates debounce_channel CHANNELS times via generate.

Test Plan (CHANNELS=4, SYNC_STAGES=3, DEBOUNCE_CYCLES=4, RESET_LEVEL=0, tick=1 unless stated):
- Reset: rst=0 with sig_in=4'hF -> out=0, rise=fall=0 immediately, with no clk edge needed. Release rst with sig_in held at 4'hF -> out=4'hF on the 8th edge, rise=4'hF for exactly 1 cycle.
- Clean step on ch0 0->1 at edge E -> out[0]=1 and rise[0]=1 after edge E+7; rise[0]=0 after E+8. Reverse step -> fall[0] pulse with the same timing.
- Bounce on ch1: high 2 cycles, low 1, high 3, then low -> out[1] stays 0, rise[1] never asserts. Holding high 8+ cycles afterwards -> single rise.
- Tick gating: tick pulses every 4th cycle, ch2 step -> out[2] toggles only on the 4th qualifying tick after the FSM enters WAIT. Counter holds between ticks.
- Mid-debounce reset: ch3 stepped, rst=0 three cycles later -> out[3]=0, no rise, FSM returns to STABLE_LO.
- Simultaneous events: ch0 rising while ch1 falling on the same cycle -> rise=4'b0001 and fall=4'b0010 on the same cycle.
